// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, talks to instruction memory and fills the
// IF/ID pipeline register, honouring hazard holds, EX-stage redirects and HLT.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall,
  input  logic        ifid_stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc1,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [3:0]  OP_HLT = 4'hF;
  localparam logic [15:0] NOP    = 16'h0000;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc1_q, pc1_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic        hold;
  logic        accept;
  logic [15:0] pc_inc;

  assign hold   = pc_stall | ifid_stall;
  assign accept = imem_ready & ~hold & ~redirect_valid & (state_q != S_HALT);
  assign pc_inc = pc_q + 16'd1;

  // Next-state and IF/ID update; redirect outranks halt, hold and memory response.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    if (redirect_valid) begin
      state_d = S_FETCH;
      pc_d    = redirect_target;
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (state_q == S_HALT) begin
      if (!hold) begin
        instr_d = NOP;
        valid_d = 1'b0;
      end else begin
        instr_d = instr_q;
        valid_d = valid_q;
      end
    end else if (hold) begin
      // A beat arriving under hold is dropped; the same address is re-requested.
      state_d = imem_ready ? S_FETCH : S_WAIT;
    end else if (accept) begin
      pc_d    = pc_inc;
      instr_d = imem_rdata;
      pc1_d   = pc_inc;
      valid_d = 1'b1;
      state_d = (imem_rdata[15:12] == OP_HLT) ? S_HALT : S_FETCH;
    end else begin
      state_d = S_WAIT;
      instr_d = NOP;
      valid_d = 1'b0;
    end
    halted_d = (state_d == S_HALT);
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= 16'h0000;
      instr_q  <= 16'h0000;
      pc1_q    <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc1_q    <= pc1_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign imem_req   = (state_q != S_HALT);
  assign imem_addr  = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc1   = pc1_q;
  assign ifid_valid = valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus randomized traffic,
// each cycle's expected outputs come from a behavioural model of the fetch rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, pc_stall, ifid_stall, redirect_valid, imem_ready;
  logic [15:0] redirect_target, imem_rdata;
  logic        imem_req, ifid_valid, halted;
  logic [15:0] imem_addr, ifid_instr, ifid_pc1;

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .imem_req(imem_req),
    .imem_addr(imem_addr), .ifid_instr(ifid_instr), .ifid_pc1(ifid_pc1),
    .ifid_valid(ifid_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pc1;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (architectural view: PC, halted flag, IF/ID contents).
  logic [15:0] m_pc = 16'h0000;
  logic        m_halt = 1'b0;
  logic [15:0] m_instr = 16'h0000;
  logic [15:0] m_pc1 = 16'h0000;
  logic        m_valid = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("imem_req",   {15'd0, imem_req},   {15'd0, e.req});
      chk("imem_addr",  imem_addr,           e.addr);
      chk("ifid_instr", ifid_instr,          e.instr);
      chk("ifid_pc1",   ifid_pc1,            e.pc1);
      chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, e.valid});
      chk("halted",     {15'd0, halted},     {15'd0, e.halted});
    end
  end

  // Apply one cycle of inputs, advance the model, queue the expected post-edge view.
  task automatic step(input logic r, input logic ps, input logic is, input logic rv,
                      input logic [15:0] rt, input logic rdy, input logic [15:0] rd);
    exp_t e;
    rst = r; pc_stall = ps; ifid_stall = is; redirect_valid = rv;
    redirect_target = rt; imem_ready = rdy; imem_rdata = rd;
    if (r) begin
      m_pc = 16'h0000; m_halt = 1'b0; m_instr = 16'h0000; m_pc1 = 16'h0000; m_valid = 1'b0;
    end else if (rv) begin
      m_pc = rt; m_halt = 1'b0; m_instr = 16'h0000; m_valid = 1'b0;
    end else if (m_halt) begin
      if (!(ps || is)) begin m_instr = 16'h0000; m_valid = 1'b0; end
    end else if (ps || is) begin
      // frozen: nothing moves, the beat is dropped
    end else if (rdy) begin
      m_instr = rd;
      m_pc1   = 16'((int'(m_pc) + 1) % 65536);
      m_pc    = m_pc1;
      m_valid = 1'b1;
      m_halt  = (rd >> 12) == 16'd15;
    end else begin
      m_instr = 16'h0000; m_valid = 1'b0;
    end
    e.req = ~m_halt; e.addr = m_pc; e.instr = m_instr;
    e.pc1 = m_pc1; e.valid = m_valid; e.halted = m_halt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input logic [15:0] rd);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, rdy, rd);
  endtask

  initial begin
    rst = 1'b1; pc_stall = 1'b0; ifid_stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = 16'h0000; imem_ready = 1'b0; imem_rdata = 16'h0000;

    // Reset with every other input active.
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 16'hF000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);

    // Back-to-back fetch at 0,1,2 then up to PC=5.
    for (int i = 0; i < 5; i++) idle(1'b1, 16'(16'h1000 + i));

    // Memory not ready for three cycles at PC=5, then the word arrives.
    for (int i = 0; i < 3; i++) idle(1'b0, 16'hDEAD);
    idle(1'b1, 16'h2005);

    // Full hold with ready beats, then release at the same address.
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hBAD0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hBAD1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBAD2);
    idle(1'b1, 16'h2006);

    // Redirect beats hold and a same-cycle memory beat.
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b1, 16'h3333);
    idle(1'b1, 16'h4040);

    // HLT at PC=7, idle in halt (held and not), then redirect out to 0x0010.
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b0, 16'h0000);
    idle(1'b1, 16'hF000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111);
    idle(1'b1, 16'h1112);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000);
    idle(1'b1, 16'h5010);

    // PC wrap from 0xFFFF.
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000);
    idle(1'b1, 16'h6FFF);
    idle(1'b1, 16'h6000);

    // Reset in the middle of a wait and in the middle of a halt.
    idle(1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    idle(1'b1, 16'hF123);
    idle(1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777);
    idle(1'b1, 16'h7000);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic        r, ps, is, rv, rdy;
      logic [15:0] rt, rd;
      r   = ($urandom_range(0, 99) < 2);
      ps  = ($urandom_range(0, 99) < 15);
      is  = ($urandom_range(0, 99) < 15);
      rv  = ($urandom_range(0, 99) < 10);
      rdy = ($urandom_range(0, 99) < 70);
      rt  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      rd  = 16'($urandom);
      step(r, ps, is, rv, rt, rdy, rd);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
